// File: rtl/div.sv
// Multi-cycle 32-bit divider for the EX stage: restoring shift-subtract, one
// quotient bit per cycle, signed or unsigned, result {remainder, quotient}.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] work;     // {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [31:0] dvsr;
  logic        neg_q, neg_r;

  logic        s1, s2;
  logic [32:0] top;
  logic [31:0] diff, q_fix, r_fix;
  logic        ge;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  always_comb begin
    s1    = signed_div_i & opdata1_i[31];
    s2    = signed_div_i & opdata2_i[31];
    // remainder is always < divisor, so a set top[32] guarantees the subtract fits
    top   = work[63:31];
    ge    = top >= {1'b0, dvsr};
    diff  = top[31:0] - dvsr;
    q_fix = neg_q ? neg32(work[31:0])  : work[31:0];
    r_fix = neg_r ? neg32(work[63:32]) : work[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      ready_o  <= 1'b0;
      result_o <= 64'h0;
      work     <= 64'h0;
      dvsr     <= 32'h0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'h0;
          if (start_i && !annul_i) begin
            work  <= {32'h0, s1 ? neg32(opdata1_i) : opdata1_i};
            dvsr  <= s2 ? neg32(opdata2_i) : opdata2_i;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            cnt   <= 6'd0;
            state <= (opdata2_i == 32'h0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          // ready is raised by END itself, giving the zero-divisor path its extra cycle
          result_o <= 64'h0;
          ready_o  <= 1'b0;
          state    <= annul_i ? FREE : END;
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt == 6'd32) begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            work <= ge ? {diff, work[30:0], 1'b1} : {work[62:0], 1'b0};
            cnt  <= cnt + 6'd1;
          end
        end
        END: begin
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            ready_o  <= 1'b0;
            result_o <= 64'h0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Randomized bench for div: arithmetic reference model plus a per-cycle
// comparison of ready_o/result_o against the expected handshake timing.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, acc = 0, lat = 33;
  bit          busy = 1'b0, chk_en = 1'b0;
  logic [63:0] exp_res = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb; r = sa % sb;
    return {r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Per-cycle check, 1 time unit after each rising edge
  initial begin
    bit exp_rdy;
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        exp_rdy = busy && ((cyc - acc) >= lat);
        check("ready_o", {63'h0, ready_o}, {63'h0, exp_rdy});
        if (exp_rdy)   check("result_o", result_o, exp_res);
        else if (!busy) check("idle_result", result_o, 64'h0);
      end
    end
  end

  // abort_at >= 0 aborts that many cycles after acceptance, via rst or annul_i
  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                     input int abort_at, input bit use_rst);
    int n;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    exp_res = model(s, a, b);
    lat     = (b == 32'h0) ? 2 : 33;
    acc     = cyc + 1;
    busy    = 1'b1;
    @(negedge clk);
    signed_div_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      busy = 1'b0;
      if (use_rst) rst = 1'b1; else annul_i = 1'b1;
      @(negedge clk);
      rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    n = 0;
    while (!ready_o && n < 40) begin @(negedge clk); n++; end
    check("ready_timeout", {63'h0, ready_o}, 64'h1);
    repeat ($urandom_range(0, 2)) begin
      annul_i = 1'($urandom);
      opdata1_i = $urandom;
      @(negedge clk);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    busy    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'h0; opdata2_i = 32'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    check("pin_100_7",   model(1'b0, 32'd100, 32'd7),              {32'd2, 32'd14});
    check("pin_m7_2",    model(1'b1, 32'hFFFF_FFF9, 32'h2),        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("pin_wrap",    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});
    check("pin_u_ff_1",  model(1'b0, 32'hFFFF_FFFF, 32'h1),        {32'h0, 32'hFFFF_FFFF});
    check("pin_9_3",     model(1'b0, 32'd9, 32'd3),                {32'd0, 32'd3});
    check("pin_s_m9_4",  model(1'b1, 32'hFFFF_FFF7, 32'h4),        {32'hFFFF_FFFF, 32'hFFFF_FFFE});

    run(1'b0, 32'd100, 32'd7, -1, 1'b0);
    run(1'b1, 32'hFFFF_FFF9, 32'h2, -1, 1'b0);
    run(1'b0, 32'hFFFF_FFFF, 32'h1, -1, 1'b0);
    run(1'b1, 32'hFFFF_FFFF, 32'h1, -1, 1'b0);
    run(1'b0, 32'd1234, 32'h0, -1, 1'b0);
    run(1'b1, 32'h8000_0000, 32'h0, -1, 1'b0);
    run(1'b0, 32'd50, 32'd3, 10, 1'b0);
    run(1'b0, 32'd9, 32'd3, -1, 1'b0);
    run(1'b1, 32'd77, 32'd5, 20, 1'b1);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    run(1'b1, 32'd5, 32'h0, 0, 1'b0);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 16);
        2:       b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      run(1'($urandom), a, b, -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
